fp_align_shifter: RTL and testbench

Pre-add alignment stage for the 32-bit IEEE-754 add/sub datapath. It performs the inverse operation to the post-subtract normalizer, which left-shifts and decrements the exponent. This block orders the two operands by magnitude, computes the exponent difference, and right-shifts the smaller significand with guard/round/sticky collection. It is a 2-stage valid/ready pipeline that feeds the significand adder.

---
 rtl/fp_alu_pkg.sv | 43 ++++
 rtl/sticky_right_shifter.sv | 51 +++++
 rtl/fp_align_shifter.sv | 162 ++++++++++++++++
 tb/tb_fp_align_shifter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
// ============================================================================
// Module   : fp_alu_pkg
// Brief    : Shared widths and IEEE-754 single field helpers for the FP
//            add/sub datapath (alignment, normalisation, rounding stages).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_alu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SIG_W = MAN_W + 1;
  localparam int GRS_W = 3;
  localparam int ALN_W = SIG_W + GRS_W;
  localparam int FP_W  = 1 + EXP_W + MAN_W;
  localparam int BIAS  = 127;

  function automatic logic f_sign(input logic [FP_W-1:0] x);
    return x[FP_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [FP_W-1:0] x);
    return x[FP_W-2:MAN_W];
  endfunction

  function automatic logic [MAN_W-1:0] f_man(input logic [FP_W-1:0] x);
    return x[MAN_W-1:0];
  endfunction

  // Hidden bit is implied for every non-zero exponent field.
  function automatic logic f_hidden(input logic [FP_W-1:0] x);
    return |f_exp(x);
  endfunction

  // Denormals share the scale of exponent 1.
  function automatic logic [EXP_W-1:0] f_eff_exp(input logic [FP_W-1:0] x);
    return (f_exp(x) == '0) ? EXP_W'(1) : f_exp(x);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sticky_right_shifter.sv
// ============================================================================
// Module   : sticky_right_shifter
// Brief    : Combinational logarithmic right shifter. With STICKY_EN set, bit 0
//            of the result is ORed with every bit shifted out; otherwise the
//            shift simply truncates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sticky_right_shifter #(
  parameter int W         = 27,
  parameter int SHAMT_W   = 8,
  parameter bit STICKY_EN = 1'b1
) (
  input  logic [W-1:0]       data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [W-1:0]       data_o
);
  import fp_alu_pkg::*;

  // Stages below c_STG shift by 1,2,4,...; anything at or above 2**c_STG
  // always clears the whole word, so those shift bits collapse into w_big.
  localparam int c_STG = $clog2(W);

  logic [W-1:0] w_data [0:c_STG];
  logic         w_big;

  assign w_data[0] = data_i;
  assign w_big     = |shamt_i[SHAMT_W-1:c_STG];

  for (genvar k = 0; k < c_STG; k++) begin : g_stage
    localparam int c_SH = 1 << k;
    assign w_data[k+1] = shamt_i[k] ? (w_data[k] >> c_SH) : w_data[k];
  end

  if (STICKY_EN) begin : g_sticky
    logic [c_STG:0] w_stk;
    assign w_stk[0] = 1'b0;
    for (genvar k = 0; k < c_STG; k++) begin : g_stk_stage
      localparam int c_SH = 1 << k;
      assign w_stk[k+1] = w_stk[k] | (shamt_i[k] & (|w_data[k][c_SH-1:0]));
    end
    assign data_o = w_big ? {{(W-1){1'b0}}, |data_i}
                          : {w_data[c_STG][W-1:1], w_data[c_STG][0] | w_stk[c_STG]};
  end else begin : g_trunc
    assign data_o = w_big ? '0 : w_data[c_STG];
  end

endmodule

`default_nettype wire

// File: rtl/fp_align_shifter.sv
// ============================================================================
// Module   : fp_align_shifter
// Brief    : Two-stage valid/ready pre-add alignment. Stage 1 orders the
//            operands by magnitude and computes the exponent difference;
//            stage 2 right-shifts the smaller significand into GRS format.
// Config   : FP_ALIGN_STICKY_EN - when defined, bit 0 of significand_small
//            collects sticky from shifted-out bits; otherwise it truncates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_align_shifter #(
  parameter int EXP_W = fp_alu_pkg::EXP_W,
  parameter int MAN_W = fp_alu_pkg::MAN_W,
  parameter int GRS_W = fp_alu_pkg::GRS_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   operand_a,
  input  logic [EXP_W+MAN_W:0]   operand_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sign_large,
  output logic                   sign_small,
  output logic [EXP_W-1:0]       exponent_large,
  output logic [MAN_W+GRS_W:0]   significand_large,
  output logic [MAN_W+GRS_W:0]   significand_small,
  output logic                   swapped
);
  import fp_alu_pkg::*;

  localparam int c_SIG_W = MAN_W + 1;
  localparam int c_ALN_W = c_SIG_W + GRS_W;
  localparam int c_FP_W  = 1 + EXP_W + MAN_W;
`ifdef FP_ALIGN_STICKY_EN
  localparam bit c_STICKY_EN = 1'b1;
`else
  localparam bit c_STICKY_EN = 1'b0;
`endif

  // Handshake
  logic w_s1_adv, w_s2_adv, w_s1_load, w_s2_load;

  // Stage 1 state
  logic               s1_valid_q, s1_valid_d;
  logic               s1_sign_l_q, s1_sign_l_d;
  logic               s1_sign_s_q, s1_sign_s_d;
  logic [EXP_W-1:0]   s1_exp_l_q, s1_exp_l_d;
  logic [c_SIG_W-1:0] s1_sig_l_q, s1_sig_l_d;
  logic [c_SIG_W-1:0] s1_sig_s_q, s1_sig_s_d;
  logic [EXP_W-1:0]   s1_diff_q, s1_diff_d;
  logic               s1_swap_q, s1_swap_d;

  // Stage 2 state (drives the outputs directly)
  logic               s2_valid_q, s2_valid_d;
  logic               s2_sign_l_q, s2_sign_s_q;
  logic [EXP_W-1:0]   s2_exp_l_q;
  logic [c_ALN_W-1:0] s2_sig_l_q, s2_sig_s_q;
  logic               s2_swap_q;

  logic [c_FP_W-1:0]  w_large, w_small;
  logic               w_swap;
  logic [c_ALN_W-1:0] w_aligned;

  assign w_s2_adv  = !s2_valid_q | out_ready;
  assign w_s1_adv  = !s1_valid_q | w_s2_adv;
  assign w_s1_load = in_valid & w_s1_adv;
  assign w_s2_load = s1_valid_q & w_s2_adv;

  // Stage 1 next state: magnitude ordering (B wins only when strictly larger)
  always_comb begin
    w_swap      = operand_b[c_FP_W-2:0] > operand_a[c_FP_W-2:0];
    w_large     = w_swap ? operand_b : operand_a;
    w_small     = w_swap ? operand_a : operand_b;
    s1_valid_d  = w_s1_adv ? in_valid : s1_valid_q;
    s1_sign_l_d = f_sign(w_large);
    s1_sign_s_d = f_sign(w_small);
    s1_exp_l_d  = f_eff_exp(w_large);
    s1_sig_l_d  = {f_hidden(w_large), f_man(w_large)};
    s1_sig_s_d  = {f_hidden(w_small), f_man(w_small)};
    // Ordering by {exp,man} guarantees the large effective exponent is >= small.
    s1_diff_d   = f_eff_exp(w_large) - f_eff_exp(w_small);
    s1_swap_d   = w_swap;
  end

  // Stage 1 registers: valid advances every cycle, payload only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_l_q <= 1'b0;
      s1_sign_s_q <= 1'b0;
      s1_exp_l_q  <= '0;
      s1_sig_l_q  <= '0;
      s1_sig_s_q  <= '0;
      s1_diff_q   <= '0;
      s1_swap_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (w_s1_load) begin
        s1_sign_l_q <= s1_sign_l_d;
        s1_sign_s_q <= s1_sign_s_d;
        s1_exp_l_q  <= s1_exp_l_d;
        s1_sig_l_q  <= s1_sig_l_d;
        s1_sig_s_q  <= s1_sig_s_d;
        s1_diff_q   <= s1_diff_d;
        s1_swap_q   <= s1_swap_d;
      end
    end
  end

  sticky_right_shifter #(
    .W         (c_ALN_W),
    .SHAMT_W   (EXP_W),
    .STICKY_EN (c_STICKY_EN)
  ) u_shift (
    .data_i  ({s1_sig_s_q, {GRS_W{1'b0}}}),
    .shamt_i (s1_diff_q),
    .data_o  (w_aligned)
  );

  // Stage 2 valid: holds while the downstream stalls
  always_comb begin
    s2_valid_d = w_s2_adv ? s1_valid_q : s2_valid_q;
  end

  // Stage 2 registers: captured only when stage 1 hands over a result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_sign_l_q <= 1'b0;
      s2_sign_s_q <= 1'b0;
      s2_exp_l_q  <= '0;
      s2_sig_l_q  <= '0;
      s2_sig_s_q  <= '0;
      s2_swap_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (w_s2_load) begin
        s2_sign_l_q <= s1_sign_l_q;
        s2_sign_s_q <= s1_sign_s_q;
        s2_exp_l_q  <= s1_exp_l_q;
        s2_sig_l_q  <= {s1_sig_l_q, {GRS_W{1'b0}}};
        s2_sig_s_q  <= w_aligned;
        s2_swap_q   <= s1_swap_q;
      end
    end
  end

  assign in_ready          = w_s1_adv;
  assign out_valid         = s2_valid_q;
  assign sign_large        = s2_sign_l_q;
  assign sign_small        = s2_sign_s_q;
  assign exponent_large    = s2_exp_l_q;
  assign significand_large = s2_sig_l_q;
  assign significand_small = s2_sig_s_q;
  assign swapped           = s2_swap_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_align_shifter.sv
// ============================================================================
// Module   : tb_fp_align_shifter
// Brief    : Self-checking bench for fp_align_shifter with a behavioural
//            reference model, directed vectors, backpressure, random traffic
//            and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_align_shifter;

  typedef struct packed {
    logic        sl;
    logic        ss;
    logic [7:0]  e;
    logic [26:0] gl;
    logic [26:0] gs;
    logic        sw;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        in_ready, out_valid, sign_large, sign_small, swapped;
  logic [7:0]  exponent_large;
  logic [26:0] significand_large, significand_small;
  res_t        obs;

  int   n_checks = 0;
  int   n_errors = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  fp_align_shifter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .operand_a         (operand_a),
    .operand_b         (operand_b),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .sign_large        (sign_large),
    .sign_small        (sign_small),
    .exponent_large    (exponent_large),
    .significand_large (significand_large),
    .significand_small (significand_small),
    .swapped           (swapped)
  );

  assign obs = {sign_large, sign_small, exponent_large, significand_large,
                significand_small, swapped};

  // Reference: order by magnitude, scale by exponent gap with plain arithmetic.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    logic [31:0] big, sm;
    longint      ma, mb, el, es, sig_l, sig_s, ext, res, diff;
    ma = longint'(a[30:0]);
    mb = longint'(b[30:0]);
    r.sw  = (mb > ma);
    big   = r.sw ? b : a;
    sm    = r.sw ? a : b;
    el    = (big[30:23] == 8'd0) ? 1 : longint'(big[30:23]);
    es    = (sm[30:23] == 8'd0) ? 1 : longint'(sm[30:23]);
    sig_l = ((big[30:23] != 8'd0) ? 64'h80_0000 : 0) + longint'(big[22:0]);
    sig_s = ((sm[30:23] != 8'd0) ? 64'h80_0000 : 0) + longint'(sm[22:0]);
    diff  = el - es;
    ext   = sig_s * 8;
    if (diff >= 27) res = 0;
    else            res = ext / (64'd1 << diff);
`ifdef FP_ALIGN_STICKY_EN
    if (diff >= 27) res = (sig_s != 0) ? 1 : 0;
    else if (res * (64'd1 << diff) != ext) res = res | 1;
`endif
    r.sl = big[31];
    r.ss = sm[31];
    r.e  = el[7:0];
    r.gl = 27'(sig_l * 8);
    r.gs = 27'(res);
    return r;
  endfunction

  task automatic gen_pair(output logic [31:0] a, output logic [31:0] b);
    int   mode;
    int   d;
    logic [7:0] ea;
    a    = $urandom;
    mode = $urandom_range(0, 4);
    b    = $urandom;
    ea   = a[30:23];
    case (mode)
      1: b = {~a[31], a[30:0]};
      2: begin
        d = $urandom_range(0, 30);
        b[30:23] = (int'(ea) > d) ? 8'(int'(ea) - d) : 8'd0;
      end
      3: b[30:23] = 8'd0;
      4: a[30:23] = 8'hFF;
      default: ;
    endcase
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_checks++;
    if (obs !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got %h expected 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] va [0:5];
    logic [31:0] vb [0:5];
    res_t        ve [0:5];
    logic [26:0] gs24, gs73;
    res_t        m;
`ifdef FP_ALIGN_STICKY_EN
    gs24 = 27'h5;
    gs73 = 27'h1;
`else
    gs24 = 27'h4;
    gs73 = 27'h0;
`endif
    va[0] = 32'h4040_0000; vb[0] = 32'h3F80_0000;
    ve[0] = {1'b0, 1'b0, 8'h80, 27'h600_0000, 27'h200_0000, 1'b0};
    va[1] = 32'h3F80_0000; vb[1] = 32'h4040_0000;
    ve[1] = {1'b0, 1'b0, 8'h80, 27'h600_0000, 27'h200_0000, 1'b1};
    va[2] = 32'h4B80_0000; vb[2] = 32'h3F80_0001;
    ve[2] = {1'b0, 1'b0, 8'h97, 27'h400_0000, gs24, 1'b0};
    va[3] = 32'h6400_0000; vb[3] = 32'h3F80_0000;
    ve[3] = {1'b0, 1'b0, 8'hC8, 27'h400_0000, gs73, 1'b0};
    va[4] = 32'h4000_0000; vb[4] = 32'hC000_0000;
    ve[4] = {1'b0, 1'b1, 8'h80, 27'h400_0000, 27'h400_0000, 1'b0};
    va[5] = 32'h0000_0003; vb[5] = 32'h0080_0000;
    ve[5] = {1'b0, 1'b0, 8'h01, 27'h400_0000, 27'h000_0018, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      operand_a = va[i];
      operand_b = vb[i];
      m = model(va[i], vb[i]);
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL dir%0d_latency1: out_valid got %b expected 0", i, out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || obs !== ve[i]) begin
        n_errors++;
        $display("FAIL dir%0d_const: got v=%b %h expected v=1 %h", i, out_valid, obs, ve[i]);
      end
      n_checks++;
      if (obs !== m) begin
        n_errors++;
        $display("FAIL dir%0d_model: got %h expected %h", i, obs, m);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pa [0:3];
    logic [31:0] pb [0:3];
    int   idx;
    int   got;
    res_t e;
    for (int i = 0; i < 4; i++) gen_pair(pa[i], pb[i]);
    exp_q.delete();
    idx = 0;
    got = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      in_valid  = (idx < 4);
      operand_a = pa[idx % 4];
      operand_b = pb[idx % 4];
      #1;
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0 || obs !== exp_q[0]) begin
          n_errors++;
          $display("FAIL bp_hold c%0d: got %h expected %h", c, obs,
                   (exp_q.size() != 0) ? exp_q[0] : res_t'(0));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(operand_a, operand_b));
        idx++;
      end
    end
    n_checks++;
    if (idx != 2 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_accepts: got %0d accepts in_ready=%b expected 2 accepts in_ready=0",
               idx, in_ready);
    end
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (idx < 4);
      operand_a = pa[idx % 4];
      operand_b = pb[idx % 4];
      #1;
      if (out_valid) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : res_t'(0);
        got++;
        n_checks++;
        if (obs !== e) begin
          n_errors++;
          $display("FAIL bp_order%0d: got %h expected %h", got, obs, e);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(operand_a, operand_b));
        idx++;
      end
    end
    n_checks++;
    if (got != 4) begin
      n_errors++;
      $display("FAIL bp_count: got %0d results expected 4", got);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic        hold_pend;
    res_t        held;
    res_t        e;
    logic [31:0] a, b;
    hold_pend = 1'b0;
    held      = '0;
    exp_q.delete();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (hold_pend) begin
        n_checks++;
        if (out_valid !== 1'b1 || obs !== held) begin
          n_errors++;
          $display("FAIL rnd_hold c%0d: got v=%b %h expected v=1 %h", c, out_valid, obs, held);
        end
        hold_pend = 1'b0;
      end
      gen_pair(a, b);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      operand_a = a;
      operand_b = b;
      #1;
      if (out_valid) begin
        if (out_ready) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : res_t'(0);
          n_checks++;
          if (obs !== e) begin
            n_errors++;
            $display("FAIL rnd_data c%0d: got %h expected %h", c, obs, e);
          end
        end else begin
          hold_pend = 1'b1;
          held      = obs;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(operand_a, operand_b));
    end
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
          n_errors++;
          $display("FAIL rnd_drain: got %h expected %h", obs, e);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL rnd_lost: got %0d results outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    operand_a = 32'h4040_0000;
    operand_b = 32'hBF80_0001;
    @(negedge clk);
    operand_a = 32'h3F80_0000;
    operand_b = 32'h4B80_0000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL rstmid_full: got out_valid=%b in_ready=%b expected 1 0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
      n_errors++;
      $display("FAIL rstmid_async: got v=%b r=%b %h expected v=0 r=1 0", out_valid, in_ready, obs);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL rstmid_stale c%0d: got v=%b r=%b expected v=0 r=1", c, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
